// File: rtl/lsq_data_mem.sv
// lsq_data_mem: byte-addressed data memory behind the load/store queue.
// Commits sb/sh/sw stores and serves lb/lh/lw/lbu/lhu loads through a
// LOAD_LAT-deep result pipeline that accepts one load per cycle and can be flushed.
// Optional feature macro: LSQ_DMEM_FWD_EN. When it is defined, a load is accepted
// in the same cycle as a store. The read then merges the committing store's bytes
// (write-first). When it is undefined, the store has priority and the load stalls.
// Memory contents have no reset. They rely on the zero power-up image of the device.

module lsq_data_mem #(
   parameter int DEPTH_BYTES = 204800,
   parameter int ADDR_W      = 32,
   parameter int LOAD_LAT    = 2,
   parameter int ROB_W       = 5,
   parameter int PREG_W      = 7
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              st_valid,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [2:0]        st_func3,
   input  logic [31:0]       st_data,
   output logic              st_err,
   input  logic              ld_req_valid,
   output logic              ld_req_ready,
   input  logic [ADDR_W-1:0] ld_req_addr,
   input  logic [2:0]        ld_req_func3,
   input  logic [ROB_W-1:0]  ld_req_rob,
   input  logic [PREG_W-1:0] ld_req_pd,
   input  logic              flush,
   output logic              ld_valid,
   output logic [31:0]       ld_data,
   output logic [ROB_W-1:0]  ld_rob,
   output logic [PREG_W-1:0] ld_pd,
   output logic              ld_err
);

   localparam int IDX_W = $clog2(DEPTH_BYTES);
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

   logic [7:0]        mem [DEPTH_BYTES];
   logic [2:0]        stLen;
   logic [2:0]        stLenM1;
   logic              stOk;
   logic              stWrite;
   logic [IDX_W-1:0]  stIdx;
   logic [2:0]        ldLenM1;
   logic              ldFuncOk;
   logic              ldOk;
   logic              ldAccept;
   logic [IDX_W-1:0]  ldIdx;
   logic [7:0]        rdByte [4];
   logic [31:0]       ldData_d;
   logic              readyEn_q;
   logic              stErr_q;
   logic [LOAD_LAT-1:0] vld_q;
   logic [31:0]       data_q [LOAD_LAT];
   logic [ROB_W-1:0]  rob_q  [LOAD_LAT];
   logic [PREG_W-1:0] pd_q   [LOAD_LAT];
   logic              err_q  [LOAD_LAT];

   // Store decode: size from func3, and whether the whole access is legal and fits in memory
   always_comb begin
      stLen   = 3'd0;
      stLenM1 = 3'd0;
      case (st_func3)
         3'b000:  begin stLen = 3'd1; stLenM1 = 3'd0; end
         3'b001:  begin stLen = 3'd2; stLenM1 = 3'd1; end
         3'b010:  begin stLen = 3'd4; stLenM1 = 3'd3; end
         default: begin stLen = 3'd0; stLenM1 = 3'd0; end
      endcase
      stOk    = (stLen != 3'd0) &&
                (({1'b0, st_addr} + (ADDR_W+1)'(stLenM1)) < DEPTH_EXT);
      stWrite = st_valid && stOk;
      stIdx   = st_addr[IDX_W-1:0];
   end

   // Load decode, acceptance and the accept-cycle read, including optional store merge
   always_comb begin
      ldLenM1  = 3'd0;
      ldFuncOk = 1'b0;
      case (ld_req_func3)
         3'b000, 3'b100: begin ldLenM1 = 3'd0; ldFuncOk = 1'b1; end
         3'b001, 3'b101: begin ldLenM1 = 3'd1; ldFuncOk = 1'b1; end
         3'b010:         begin ldLenM1 = 3'd3; ldFuncOk = 1'b1; end
         default:        begin ldLenM1 = 3'd0; ldFuncOk = 1'b0; end
      endcase
      ldOk  = ldFuncOk &&
              (({1'b0, ld_req_addr} + (ADDR_W+1)'(ldLenM1)) < DEPTH_EXT);
      ldIdx = ld_req_addr[IDX_W-1:0];
`ifdef LSQ_DMEM_FWD_EN
      ld_req_ready = readyEn_q & ~flush;
`else
      ld_req_ready = readyEn_q & ~flush & ~st_valid;
`endif
      ldAccept = ld_req_valid && ld_req_ready;
      for (int i = 0; i < 4; i++) begin
         rdByte[i] = mem[ldIdx + IDX_W'(i)];
`ifdef LSQ_DMEM_FWD_EN
         if (stWrite && (((ld_req_addr + ADDR_W'(i)) - st_addr) < ADDR_W'(stLen)))
            rdByte[i] = st_data[{((ld_req_addr[1:0] + 2'(i)) - st_addr[1:0]), 3'b000} +: 8];
`endif
      end
      ldData_d = 32'd0;
      if (ldOk) begin
         case (ld_req_func3)
            3'b000:  ldData_d = {{24{rdByte[0][7]}}, rdByte[0]};
            3'b001:  ldData_d = {{16{rdByte[1][7]}}, rdByte[1], rdByte[0]};
            3'b010:  ldData_d = {rdByte[3], rdByte[2], rdByte[1], rdByte[0]};
            3'b100:  ldData_d = {24'd0, rdByte[0]};
            3'b101:  ldData_d = {16'd0, rdByte[1], rdByte[0]};
            default: ldData_d = 32'd0;
         endcase
      end
   end

   // Byte-wise store commit; the array is deliberately outside the reset domain
   always_ff @(posedge clk) begin
      if (stWrite) begin
         for (int i = 0; i < 4; i++) begin
            if (3'(i) < stLen)
               mem[stIdx + IDX_W'(i)] <= st_data[8*i +: 8];
         end
      end
   end

   // Result pipeline, store error pulse and the post-reset ready enable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readyEn_q <= 1'b0;
         stErr_q   <= 1'b0;
         vld_q     <= '0;
         for (int i = 0; i < LOAD_LAT; i++) begin
            data_q[i] <= 32'd0;
            rob_q[i]  <= '0;
            pd_q[i]   <= '0;
            err_q[i]  <= 1'b0;
         end
      end else begin
         readyEn_q <= 1'b1;
         stErr_q   <= st_valid & ~stOk;
         vld_q[0]  <= ldAccept;
         data_q[0] <= ldData_d;
         rob_q[0]  <= ld_req_rob;
         pd_q[0]   <= ld_req_pd;
         err_q[0]  <= ~ldOk;
         for (int i = 1; i < LOAD_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            data_q[i] <= data_q[i-1];
            rob_q[i]  <= rob_q[i-1];
            pd_q[i]   <= pd_q[i-1];
            err_q[i]  <= err_q[i-1];
         end
         if (flush)
            vld_q <= '0;
      end
   end

   assign st_err   = stErr_q;
   assign ld_valid = vld_q[LOAD_LAT-1];
   assign ld_data  = data_q[LOAD_LAT-1];
   assign ld_rob   = rob_q[LOAD_LAT-1];
   assign ld_pd    = pd_q[LOAD_LAT-1];
   assign ld_err   = err_q[LOAD_LAT-1];

endmodule

// File: tb/tb_lsq_data_mem.sv
// tb_lsq_data_mem: directed test of lsq_data_mem with hand-computed expectations.
// It checks the reset state, stores and loads, sign and zero extension, range errors,
// back-to-back throughput, flush, store/load conflicts and reset with loads in flight.

module tb_lsq_data_mem;

   localparam int D   = 204800;
   localparam int LAT = 2;

   logic        clk;
   logic        reset_n;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [2:0]  st_func3;
   logic [31:0] st_data;
   logic        st_err;
   logic        ld_req_valid;
   logic        ld_req_ready;
   logic [31:0] ld_req_addr;
   logic [2:0]  ld_req_func3;
   logic [4:0]  ld_req_rob;
   logic [6:0]  ld_req_pd;
   logic        flush;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic [4:0]  ld_rob;
   logic [6:0]  ld_pd;
   logic        ld_err;

   int vectors;
   int miscompares;

   lsq_data_mem #(.DEPTH_BYTES(D), .ADDR_W(32), .LOAD_LAT(LAT), .ROB_W(5), .PREG_W(7)) dut (
      .clk(clk), .reset_n(reset_n),
      .st_valid(st_valid), .st_addr(st_addr), .st_func3(st_func3), .st_data(st_data),
      .st_err(st_err),
      .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
      .ld_req_func3(ld_req_func3), .ld_req_rob(ld_req_rob), .ld_req_pd(ld_req_pd),
      .flush(flush),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_rob(ld_rob), .ld_pd(ld_pd), .ld_err(ld_err)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic doStore(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
      @(negedge clk);
      st_valid = 1'b1; st_addr = a; st_func3 = f; st_data = d;
      @(negedge clk);
      st_valid = 1'b0;
   endtask

   // Issues one load, waits for acceptance and completion, and returns the payload and latency
   task automatic doLoad(input logic [31:0] a, input logic [2:0] f, input logic [4:0] r,
                         input logic [6:0] p, output logic [31:0] d, output logic [4:0] ro,
                         output logic [6:0] po, output logic e, output int lat);
      int acc;
      acc = -1; lat = -1; d = '0; ro = '0; po = '0; e = 1'b0;
      @(negedge clk);
      ld_req_valid = 1'b1; ld_req_addr = a; ld_req_func3 = f; ld_req_rob = r; ld_req_pd = p;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         if (k > 0) @(negedge clk);
         if (acc >= 0) ld_req_valid = 1'b0;
         if (acc >= 0 && ld_valid) begin
            lat = k - acc; d = ld_data; ro = ld_rob; po = ld_pd; e = ld_err;
         end
         #1;
         if (acc < 0 && ld_req_ready) acc = k;
      end
      ld_req_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; st_valid = 0; st_addr = 0; st_func3 = 0; st_data = 0;
      ld_req_valid = 0; ld_req_addr = 0; ld_req_func3 = 0; ld_req_rob = 0; ld_req_pd = 0;
      flush = 0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({ld_valid, st_err, ld_req_ready, ld_err} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_flags got %b exp 0000", {ld_valid, st_err, ld_req_ready, ld_err});
      end
      vectors++;
      if ({ld_data, ld_rob, ld_pd} !== 44'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_payload got %h exp 0", {ld_data, ld_rob, ld_pd});
      end
      reset_n = 1'b1;
      #1;
      vectors++;
      if (ld_req_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ready_before_edge got %b exp 0", ld_req_ready);
      end
      @(negedge clk);
      vectors++;
      if (ld_req_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ready_after_edge got %b exp 1", ld_req_ready);
      end
   endtask

   task automatic test_store_word;
      logic [31:0] d; logic [4:0] ro; logic [6:0] po; logic e; int lat;
      doStore(32'h10, 3'b010, 32'hDEADBEEF);
      vectors++;
      if (st_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sw_st_err got %b exp 0", st_err);
      end
      doLoad(32'h10, 3'b010, 5'd3, 7'd40, d, ro, po, e, lat);
      vectors++;
      if (lat !== LAT) begin
         miscompares++;
         $display("[TB] FAIL lw_latency got %0d exp %0d", lat, LAT);
      end
      vectors++;
      if ({d, ro, po, e} !== {32'hDEADBEEF, 5'd3, 7'd40, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL lw_payload got %h/%0d/%0d/%b exp deadbeef/3/40/0", d, ro, po, e);
      end
   endtask

   task automatic test_extension;
      logic [31:0] d; logic [4:0] ro; logic [6:0] po; logic e; int lat;
      logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] ad  [4] = '{32'h20, 32'h20, 32'h22, 32'h22};
      logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
      doStore(32'h20, 3'b000, 32'h00000080);
      doStore(32'h22, 3'b001, 32'h00008001);
      for (int i = 0; i < 4; i++) begin
         doLoad(ad[i], f3[i], 5'(i), 7'(i + 1), d, ro, po, e, lat);
         vectors++;
         if (d !== exp[i] || e !== 1'b0 || lat !== LAT) begin
            miscompares++;
            $display("[TB] FAIL ext_f3_%b got %h err %b lat %0d exp %h err 0 lat %0d",
                     f3[i], d, e, lat, exp[i], LAT);
         end
      end
   endtask

   task automatic test_range;
      logic [31:0] d; logic [4:0] ro; logic [6:0] po; logic e; int lat;
      doLoad(32'(D - 2), 3'b010, 5'd7, 7'd8, d, ro, po, e, lat);
      vectors++;
      if ({d, e} !== {32'd0, 1'b1} || lat !== LAT) begin
         miscompares++;
         $display("[TB] FAIL lw_out_of_range got %h err %b lat %0d exp 0 err 1", d, e, lat);
      end
      doStore(32'(D - 4), 3'b010, 32'h11223344);
      doLoad(32'(D - 4), 3'b010, 5'd8, 7'd9, d, ro, po, e, lat);
      vectors++;
      if ({d, e} !== {32'h11223344, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL lw_last_word got %h err %b exp 11223344 err 0", d, e);
      end
      doLoad(32'h20, 3'b011, 5'd9, 7'd10, d, ro, po, e, lat);
      vectors++;
      if ({d, e} !== {32'd0, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL ld_bad_func3 got %h err %b exp 0 err 1", d, e);
      end
      doStore(32'(D - 1), 3'b000, 32'h0000005A);
      vectors++;
      if (st_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sb_last_byte_err got %b exp 0", st_err);
      end
      doStore(32'(D - 1), 3'b010, 32'hFFFFFFFF);
      vectors++;
      if (st_err !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL sw_range_err got %b exp 1", st_err);
      end
      @(negedge clk);
      vectors++;
      if (st_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL st_err_pulse_width got %b exp 0", st_err);
      end
      doLoad(32'(D - 1), 3'b100, 5'd10, 7'd11, d, ro, po, e, lat);
      vectors++;
      if ({d, e} !== {32'h0000005A, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL last_byte_unchanged got %h err %b exp 5a err 0", d, e);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ad  [3] = '{32'h20, 32'h22, 32'h10};
      logic [2:0]  f3  [3] = '{3'b100, 3'b101, 3'b010};
      logic [31:0] exp [3] = '{32'h00000080, 32'h00008001, 32'hDEADBEEF};
      int cnt;
      cnt = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (ld_valid) begin
            vectors++;
            if (cnt >= 3 || k !== cnt + LAT || ld_rob !== 5'(cnt + 5) || ld_data !== exp[cnt % 3]) begin
               miscompares++;
               $display("[TB] FAIL b2b_result_%0d got rob %0d data %h at %0d exp rob %0d data %h at %0d",
                        cnt, ld_rob, ld_data, k, cnt + 5, exp[cnt % 3], cnt + LAT);
            end
            cnt++;
         end
         if (k < 3) begin
            ld_req_valid = 1'b1; ld_req_addr = ad[k]; ld_req_func3 = f3[k];
            ld_req_rob = 5'(k + 5); ld_req_pd = 7'(k + 20);
            #1;
            vectors++;
            if (ld_req_ready !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL b2b_ready_%0d got %b exp 1", k, ld_req_ready);
            end
         end else begin
            ld_req_valid = 1'b0;
         end
      end
      vectors++;
      if (cnt !== 3) begin
         miscompares++;
         $display("[TB] FAIL b2b_count got %0d exp 3", cnt);
      end
   endtask

   task automatic test_flush;
      int cnt;
      cnt = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (ld_valid) begin
            vectors++;
            if (k !== LAT || ld_rob !== 5'd1) begin
               miscompares++;
               $display("[TB] FAIL flush_completion got rob %0d at %0d exp rob 1 at %0d", ld_rob, k, LAT);
            end
            cnt++;
         end
         flush = 1'b0;
         ld_req_valid = 1'b0;
         if (k < 3) begin
            ld_req_valid = 1'b1; ld_req_addr = 32'h10; ld_req_func3 = 3'b010;
            ld_req_rob = 5'(k + 1); ld_req_pd = 7'(k + 50);
         end
         if (k == 2) begin
            flush = 1'b1;
            #1;
            vectors++;
            if (ld_req_ready !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL ready_in_flush got %b exp 0", ld_req_ready);
            end
         end
      end
      vectors++;
      if (cnt !== 1) begin
         miscompares++;
         $display("[TB] FAIL flush_count got %0d exp 1", cnt);
      end
   endtask

   task automatic test_conflict;
      int acceptK, doneK;
      logic [31:0] d;
      int expAcc;
`ifdef LSQ_DMEM_FWD_EN
      expAcc = 0;
`else
      expAcc = 1;
`endif
      acceptK = -1; doneK = -1; d = '0;
      @(negedge clk);
      st_valid = 1'b1; st_addr = 32'h30; st_func3 = 3'b010; st_data = 32'hCAFEF00D;
      ld_req_valid = 1'b1; ld_req_addr = 32'h30; ld_req_func3 = 3'b010;
      ld_req_rob = 5'd9; ld_req_pd = 7'd9;
      #1;
      vectors++;
      if (ld_req_ready !== (expAcc == 0)) begin
         miscompares++;
         $display("[TB] FAIL conflict_ready got %b exp %b", ld_req_ready, expAcc == 0);
      end
      if (ld_req_ready) acceptK = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         st_valid = 1'b0;
         if (acceptK >= 0) ld_req_valid = 1'b0;
         if (ld_valid && doneK < 0) begin
            doneK = k; d = ld_data;
         end
         #1;
         if (ld_req_valid && ld_req_ready && acceptK < 0) acceptK = k;
      end
      ld_req_valid = 1'b0;
      vectors++;
      if (acceptK !== expAcc) begin
         miscompares++;
         $display("[TB] FAIL conflict_accept got %0d exp %0d", acceptK, expAcc);
      end
      vectors++;
      if (doneK !== expAcc + LAT || d !== 32'hCAFEF00D) begin
         miscompares++;
         $display("[TB] FAIL conflict_result got %h at %0d exp cafef00d at %0d", d, doneK, expAcc + LAT);
      end
   endtask

   task automatic test_reset_inflight;
      logic [31:0] d; logic [4:0] ro; logic [6:0] po; logic e; int lat;
      int seen;
      seen = 0;
      @(negedge clk);
      ld_req_valid = 1'b1; ld_req_addr = 32'h10; ld_req_func3 = 3'b010; ld_req_rob = 5'd11; ld_req_pd = 7'd1;
      @(negedge clk);
      ld_req_rob = 5'd12;
      @(negedge clk);
      ld_req_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if ({ld_valid, ld_err, st_err, ld_req_ready, ld_data, ld_rob, ld_pd} !== 48'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_inflight_outputs got %b%b%b%b %h exp all 0",
                  ld_valid, ld_err, st_err, ld_req_ready, {ld_data, ld_rob, ld_pd});
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ld_valid) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("[TB] FAIL valid_after_reset got %0d pulses exp 0", seen);
      end
      doLoad(32'h10, 3'b010, 5'd13, 7'd2, d, ro, po, e, lat);
      vectors++;
      if ({d, e} !== {32'hDEADBEEF, 1'b0} || lat !== LAT) begin
         miscompares++;
         $display("[TB] FAIL mem_kept_over_reset got %h err %b lat %0d exp deadbeef err 0", d, e, lat);
      end
   endtask

   // Runs every scenario in order, then prints the summary
   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_store_word();
      test_extension();
      test_range();
      test_back_to_back();
      test_flush();
      test_conflict();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
